// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Dimming is enabled in the top level by defining LED_SEQ_DIM_EN.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_FILL   = 2'd2
    } led_mode_t;

    localparam int unsigned MODE_COUNT = 3;
    localparam int unsigned MS_PER_S   = 1000;

    // BOUNCE -> WRAP -> FILL -> BOUNCE
    function automatic led_mode_t next_mode(input led_mode_t m);
        logic [1:0] nxt;
        nxt = 2'((32'(m) + 1) % MODE_COUNT);
        return led_mode_t'(nxt);
    endfunction

endpackage

// File: rtl/led_seq_step_timer.sv
// Millisecond prescaler plus per-speed ms counter producing a one-cycle step strobe.
// Both counters hold while run_en is low and restart from zero on clear.
module led_seq_step_timer
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 125_000_000,
    parameter int unsigned BASE_MS    = 1000,
    parameter int unsigned NUM_SPEEDS = 2,
    parameter int unsigned SPEED_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    output logic               step
);

    localparam int unsigned PRE_TC  = CLK_HZ / MS_PER_S - 1;
    localparam int unsigned PRE_W   = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
    localparam int unsigned MS_MAX  = BASE_MS * (2 * NUM_SPEEDS - 1);
    localparam int unsigned MS_W    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [MS_W-1:0]  ms_tc;
    logic             ms_tick;
    int unsigned      period_ms;

    always_comb begin
        period_ms = BASE_MS * (2 * 32'(speed) + 1);
        ms_tc     = MS_W'(period_ms - 1);
        ms_tick   = run_en && (pre_q == PRE_W'(PRE_TC));
        // A step coinciding with a clear is dropped; the period restarts instead.
        step      = ms_tick && (ms_q == ms_tc) && !clear;
        pre_d     = pre_q;
        ms_d      = ms_q;
        if (clear) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (run_en) begin
            pre_d = ms_tick ? '0 : pre_q + 1'b1;
            if (ms_tick) begin
                ms_d = (ms_q == ms_tc) ? '0 : ms_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// N-LED pattern engine (bounce / wrap / fill) with selectable step period.
// Define LED_SEQ_DIM_EN to gate the LEDs with a 16-slot PWM of PWM_DUTY on-slots.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LEDS     = 4,
    parameter int unsigned CLK_HZ     = 125_000_000,
    parameter int unsigned BASE_MS    = 1000,
    parameter int unsigned NUM_SPEEDS = 2,
    parameter int unsigned PWM_DUTY   = 8
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               run_en,
    input  logic                                               mode_next,
    input  logic                                               speed_next,
    output logic [N_LEDS-1:0]                                  leds,
    output logic [1:0]                                         mode_o,
    output logic [((NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1)-1:0] speed_o
);

    localparam int unsigned SPEED_W = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1;
    localparam int unsigned POS_W   = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);

    led_mode_t          mode_q, mode_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_q, dir_d;   // 1 = moving down (BOUNCE only)
    logic [N_LEDS-1:0]  pattern_q, pattern_d;
    logic               clear;
    logic               step;

    assign clear = mode_next | speed_next;

    led_seq_step_timer #(
        .CLK_HZ     (CLK_HZ),
        .BASE_MS    (BASE_MS),
        .NUM_SPEEDS (NUM_SPEEDS),
        .SPEED_W    (SPEED_W)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .run_en (run_en),
        .clear  (clear),
        .speed  (speed_q),
        .step   (step)
    );

    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        pos_d   = pos_q;
        dir_d   = dir_q;

        if (mode_next) begin
            mode_d = next_mode(mode_q);
            pos_d  = '0;
            dir_d  = 1'b0;
        end
        if (speed_next) begin
            speed_d = (speed_q == SPEED_W'(NUM_SPEEDS - 1)) ? '0 : speed_q + 1'b1;
        end

        if (step && !clear) begin
            unique case (mode_q)
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        if (pos_q == LAST_POS) begin
                            pos_d = pos_q - 1'b1;
                            dir_d = 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_W'(1);
                            dir_d = 1'b0;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                end
                MODE_WRAP, MODE_FILL: begin
                    pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
                end
                default: begin
                    pos_d = '0;
                end
            endcase
        end

        for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (mode_d == MODE_FILL) begin
                pattern_d[i] = (i <= 32'(pos_d));
            end else begin
                pattern_d[i] = (i == 32'(pos_d));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_BOUNCE;
            speed_q   <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            pattern_q <= N_LEDS'(1);
        end else begin
            mode_q    <= mode_d;
            speed_q   <= speed_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            pattern_q <= pattern_d;
        end
    end

    assign mode_o  = mode_q;
    assign speed_o = speed_q;

`ifdef LED_SEQ_DIM_EN
    logic [3:0] pwm_q;

    // Free-running regardless of run_en so frozen LEDs keep their brightness.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
        end
    end

    assign leds = pattern_q & {N_LEDS{32'(pwm_q) < PWM_DUTY}};
`else
    assign leds = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed plus randomized bench for led_pattern_sequencer, checked against a
// step-index reference model of the pattern sequences.
module tb_led_pattern_sequencer;

    localparam int N    = 4;
    localparam int NS   = 2;
    localparam int CPS  = 1000;   // clock cycles per step at speed 0
    localparam int DUTY = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_en = 1'b0;
    logic       mode_next = 1'b0;
    logic       speed_next = 1'b0;
    logic [3:0] leds;
    logic [1:0] mode_o;
    logic [0:0] speed_o;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .N_LEDS     (N),
        .CLK_HZ     (1_000_000),
        .BASE_MS    (1),
        .NUM_SPEEDS (NS),
        .PWM_DUTY   (DUTY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .mode_next  (mode_next),
        .speed_next (speed_next),
        .leds       (leds),
        .mode_o     (mode_o),
        .speed_o    (speed_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: mode, speed, index within the mode's cycle, run-cycles elapsed.
    int m_mode = 0, m_speed = 0, m_idx = 0, m_el = 0, m_pwm = 0;

    function automatic int cycle_len(input int mode);
        return (mode == 0) ? 2 * (N - 1) : N;
    endfunction

    function automatic logic [3:0] dim_mask();
`ifdef LED_SEQ_DIM_EN
        return (m_pwm < DUTY) ? 4'hF : 4'h0;
`else
        return 4'hF;
`endif
    endfunction

    function automatic logic [3:0] model_leds();
        int pos;
        int pat;
        pos = (m_mode == 0 && m_idx >= N) ? 2 * (N - 1) - m_idx : m_idx;
        pat = (m_mode == 2) ? (1 << (pos + 1)) - 1 : (1 << pos);
        return 4'(pat) & dim_mask();
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_mode = 0; m_speed = 0; m_idx = 0; m_el = 0; m_pwm = 0;
        end else begin
            m_pwm = (m_pwm + 1) % 16;
            if (mode_next || speed_next) begin
                if (mode_next) begin
                    m_mode = (m_mode + 1) % 3;
                    m_idx  = 0;
                end
                if (speed_next) m_speed = (m_speed + 1) % NS;
                m_el = 0;
            end else if (run_en) begin
                m_el++;
                if (m_el == CPS * (2 * m_speed + 1)) begin
                    m_el  = 0;
                    m_idx = (m_idx + 1) % cycle_len(m_mode);
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit mn, input bit sn);
        mode_next  = mn;
        speed_next = sn;
        cyc(1);
        mode_next  = 1'b0;
        speed_next = 1'b0;
    endtask

    task automatic chk(input string tag);
        n_assert++;
        assert (leds === model_leds()) else begin
            n_fail++;
            $error("FAIL %s leds observed=%b expected=%b", tag, leds, model_leds());
        end
        n_assert++;
        assert (mode_o === 2'(m_mode)) else begin
            n_fail++;
            $error("FAIL %s mode observed=%0d expected=%0d", tag, mode_o, m_mode);
        end
        n_assert++;
        assert (speed_o === 1'(m_speed)) else begin
            n_fail++;
            $error("FAIL %s speed observed=%0d expected=%0d", tag, speed_o, m_speed);
        end
    endtask

    task automatic chk_leds(input string tag, input logic [3:0] want);
        n_assert++;
        assert (leds === (want & dim_mask())) else begin
            n_fail++;
            $error("FAIL %s leds observed=%b expected=%b", tag, leds, want & dim_mask());
        end
    endtask

    task automatic chk_ms(input string tag, input logic [1:0] want_mode,
                          input logic want_speed);
        n_assert++;
        assert (mode_o === want_mode && speed_o === want_speed) else begin
            n_fail++;
            $error("FAIL %s mode/speed observed=%0d/%0d expected=%0d/%0d",
                   tag, mode_o, speed_o, want_mode, want_speed);
        end
    endtask

    logic [3:0] t1_seq [7];
    logic [3:0] t2_seq [5];
    logic [3:0] t3_seq [4];
    int         off;
    int         lit;

    initial begin
        t1_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        t2_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        t3_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b0001};

        rst = 1'b1;
        cyc(3);
        rst    = 1'b0;
        run_en = 1'b1;
        chk("reset");
        chk_leds("reset_leds", t1_seq[0]);
        chk_ms("reset_ms", 2'd0, 1'b0);

        // Bounce through six steps
        for (int i = 1; i < 7; i++) begin
            cyc(CPS);
            chk($sformatf("bounce_step%0d", i));
            chk_leds($sformatf("bounce_leds%0d", i), t1_seq[i]);
        end

        // Mode to WRAP mid-step
        off = $urandom_range(100, 900);
        cyc(off);
        pulse(1'b1, 1'b0);
        chk("wrap_enter");
        chk_leds("wrap_enter_leds", 4'b0001);
        chk_ms("wrap_enter_ms", 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(CPS);
            chk($sformatf("wrap_step%0d", i));
            chk_leds($sformatf("wrap_leds%0d", i), t2_seq[i]);
        end

        // Mode to FILL
        off = $urandom_range(100, 900);
        cyc(off);
        pulse(1'b1, 1'b0);
        chk_leds("fill_enter_leds", 4'b0001);
        chk_ms("fill_enter_ms", 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(CPS);
            chk($sformatf("fill_step%0d", i));
            chk_leds($sformatf("fill_leds%0d", i), t3_seq[i]);
        end

        // Speed 1: three-step period restarted by the pulse
        off = $urandom_range(100, 900);
        cyc(off);
        pulse(1'b0, 1'b1);
        chk("speed1_enter");
        chk_leds("speed1_keep", 4'b0001);
        chk_ms("speed1_ms", 2'd2, 1'b1);
        cyc(3 * CPS - 1);
        chk_leds("speed1_hold", 4'b0001);
        cyc(1);
        chk_leds("speed1_step", 4'b0011);
        pulse(1'b0, 1'b1);
        chk("speed0_enter");
        chk_ms("speed0_ms", 2'd2, 1'b0);

        // Freeze mid-period, then resume for the remainder
        off = $urandom_range(100, 800);
        cyc(off);
        run_en = 1'b0;
        cyc(5000);
        chk_leds("freeze_hold", 4'b0011);
        chk("freeze");
        run_en = 1'b1;
        cyc(CPS - off - 1);
        chk_leds("resume_hold", 4'b0011);
        cyc(1);
        chk_leds("resume_step", 4'b0111);

        // Both pulses together
        pulse(1'b1, 1'b1);
        chk("both_pulses");
        chk_leds("both_leds", 4'b0001);
        chk_ms("both_ms", 2'd0, 1'b1);

        // Back to speed 0, bounce to pos 2 going down, then reset
        pulse(1'b0, 1'b1);
        cyc(4 * CPS);
        chk_leds("bounce_down2", 4'b0100);
        cyc($urandom_range(100, 900));
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_reset");
        chk_leds("mid_reset_leds", 4'b0001);
        chk_ms("mid_reset_ms", 2'd0, 1'b0);
        cyc(CPS - 1);
        chk_leds("post_reset_hold", 4'b0001);
        cyc(1);
        chk_leds("post_reset_step", 4'b0010);

        // Pulses accepted while frozen; timing stays frozen
        run_en = 1'b0;
        pulse(1'b1, 1'b0);
        chk("frozen_pulse");
        chk_ms("frozen_ms", 2'd1, 1'b0);
        cyc(3000);
        chk_leds("frozen_hold", 4'b0001);

        // Randomized traffic checked every cycle
        run_en = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            mode_next  = ($urandom_range(0, 599) == 0);
            speed_next = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 299) == 0) run_en = ~run_en;
            rst = ($urandom_range(0, 4999) == 0);
            cyc(1);
            mode_next  = 1'b0;
            speed_next = 1'b0;
            rst        = 1'b0;
            chk("random");
        end

`ifdef LED_SEQ_DIM_EN
        rst = 1'b1;
        cyc(1);
        rst    = 1'b0;
        run_en = 1'b1;
        lit    = 0;
        for (int i = 0; i < 16; i++) begin
            if (leds[0] === 1'b1) lit++;
            cyc(1);
        end
        n_assert++;
        assert (lit == DUTY) else begin
            n_fail++;
            $error("FAIL pwm_duty lit_cycles observed=%0d expected=%0d", lit, DUTY);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
